uart_rx_core: RTL and testbench
===============================

# uart_rx_core

16x-oversampling UART receiver (8N1, LSB first) sitting directly upstream of the program loader. It synchronises the raw `RX` pin and validates start bits by majority vote. On each correctly framed byte it presents `data` and raises `ready`, which the loader edge-detects to assemble 32-bit program words. Framing errors are flagged and never produce a `ready` edge.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency.
- `BAUD`, default 115200: line rate.
- `DIV`, default `CLK_HZ/(BAUD*16)` (integer division, 54 at defaults): clocks per oversample tick. Must be ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `RX`  in  1  raw serial line; asynchronous; idles high.
- `data`  out  8  last correctly framed byte; held until the next good byte.
- `ready`  out  1  level signal; rises once per good byte.
- `frame_err`  out  1  sticky flag: last frame had a low stop bit.
- `busy`  out  1  high in any state except IDLE.

## Operation
- **Input synchroniser**
  - Two flops, `RX` → `rx_s`.
  - Both flops reset to 1 so the line reads idle.
- **Prescaler**
  - Counts 0..DIV-1 and emits `tick` when the count is DIV-1, then wraps.
  - Cleared to 0 on the IDLE→START transition.
- **Sample counter**
  - 4 bits, advances on each `tick`, wraps 15→0.
  - Cleared with the prescaler.
- **Bit value**
  - Majority of `rx_s` captured at sample indices 7, 8 and 9 of the bit.
- **IDLE**
  - `rx_s`==0 → START; prescaler and sample counter cleared on that edge.
- **START**
  - At sample 15 of the start bit, majority 0 → DATA with bit index 0, and `ready` cleared.
  - Majority 1 → IDLE: false start; no output change.
- **DATA**
  - At sample 15 of each bit, the majority value is shifted in LSB first.
  - After bit index 7 → STOP.
- **STOP**
  - Decision at sample 9 of the stop bit. Deciding early leaves margin for back-to-back frames.
  - Majority 1: `data` ← shift register, `ready` ← 1, `frame_err` ← 0, → IDLE.
  - Majority 0: `frame_err` ← 1; `data` and `ready` unchanged; → BREAK.
- **BREAK**
  - Wait for `rx_s`==1, then → IDLE. Handles a held-low line or break.
- **Reset values:** `data`=0, `ready`=0, `frame_err`=0, `busy`=0, state IDLE, shift register 0.
- **Reset mid-frame:** immediate return to IDLE, no `ready`, partial byte discarded.
- **Guaranteed `ready` edge:** `ready` always falls between two good bytes, at the end of the next start bit, so the downstream edge detector sees exactly one rising edge per good byte.
- **Simultaneous events:** `reset` has priority over every transition.

## Timing
- **Reference edge e0:** the first `clk` edge that samples `RX`=0.
  - `rx_s` goes low after e1.
  - The IDLE→START transition and prescaler clear happen on e2.
- **Tick numbering:** tick n (n ≥ 1) occurs on edge e2 + n·DIV and corresponds to global sample index n-1.
- **Start decision:** global sample 15, edge e2 + 16·DIV. `ready` falls here if it was set.
- **Data bit k (0..7):** captured at global sample 16·(k+1)+15.
- **Stop decision:** global sample 153, edge e2 + 154·DIV.
  - `ready` and `data` update on that edge.
  - Latency from e0 is 154·DIV + 2 cycles.
- **Back-to-back frames:** after a good stop bit, IDLE is re-entered at sample 9 of the stop bit. A following start edge is caught with at most 2 cycles of sync delay.
- **Noise rejection:** a low glitch on `RX` shorter than 7·DIV cycles cannot pass the start vote.

## Test plan
- **Single good byte.** DIV=10 (CLK_HZ=1_600_000, BAUD=10_000); send 0xA5 with a 160-clk bit period → `ready` rises exactly 1542 cycles after e0, `data`=0xA5, `frame_err`=0.
- **Back-to-back bytes.** Send 0x00, 0xFF, 0x3C, 0x81 with no idle gap → four `ready` rising edges; `data` matches each byte in order; `ready` low between them.
- **False start.** Drive `RX` low for 50 cycles (DIV=10), then high → state returns to IDLE, no `ready` edge, `data` unchanged.
- **Framing error and recovery.** Send 0x55 with the stop bit held low for 400 cycles, then release → `frame_err`=1, no `ready` edge, `data` keeps its prior value. A following 0x12 → `ready` rises, `data`=0x12, `frame_err`=0.
- **Reset mid-frame.** Assert `reset` during data bit 4 of 0x77, release, then send 0x99 → no `ready` for 0x77; all outputs 0 during reset; then `data`=0x99 and `ready`=1.
- **Baud tolerance.** Send 0xC3 with the bit period at 160·1.03 and 160·0.97 cycles → `data`=0xC3 in both cases, `frame_err`=0.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampling 8N1 UART receiver, LSB first, with majority-vote bit sampling.
// Each correctly framed byte is presented on data with a level ready; a low stop bit sets frame_err.
module uart_rx_core #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200,
  parameter int DIV    = CLK_HZ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RX,
  output logic [7:0] data,
  output logic       ready,
  output logic       frame_err,
  output logic       busy
);

  localparam int PW = $clog2(DIV);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;

  logic          rx_m, rx_s;
  logic [PW-1:0] presc;
  logic          tick;
  logic [3:0]    samp;
  logic          s7, s8, s9;
  logic [2:0]    state;
  logic [2:0]    bitidx;
  logic [7:0]    shreg;
  logic          vote, stop_vote;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Both synchroniser flops reset high so the line reads idle out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  assign tick = (presc == PW'(DIV - 1));

  // Held at zero in IDLE, so both counters start from zero on the IDLE->START edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      samp  <= '0;
    end else if (state == IDLE) begin
      presc <= '0;
      samp  <= '0;
    end else if (tick) begin
      presc <= '0;
      samp  <= samp + 4'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tick && samp == 4'd7) s7 <= rx_s;
    if (tick && samp == 4'd8) s8 <= rx_s;
    if (tick && samp == 4'd9) s9 <= rx_s;
  end

  assign vote      = maj3(s7, s8, s9);
  // The stop bit is judged on sample 9 itself, so the live sample replaces s9.
  assign stop_vote = maj3(s7, s8, rx_s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bitidx    <= '0;
      shreg     <= '0;
      data      <= '0;
      ready     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) state <= START;
        end
        START: begin
          if (tick && samp == 4'd15) begin
            if (!vote) begin
              state  <= DATA;
              bitidx <= '0;
              ready  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick && samp == 4'd15) begin
            shreg  <= {vote, shreg[7:1]};
            bitidx <= bitidx + 3'd1;
            if (bitidx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (tick && samp == 4'd9) begin
            if (stop_vote) begin
              data      <= shreg;
              ready     <= 1'b1;
              frame_err <= 1'b0;
              state     <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end
        end
        BRK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at DIV=10: an event-time model predicts outputs from each frame's
// start edge, and a negedge process compares every output on every cycle.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int DIV       = 10;
  localparam int LAT       = 154 * DIV + 2;
  localparam int START_DEC = 16 * DIV + 2;
  localparam int K_BUSY    = 0;
  localparam int K_RDY0    = 1;
  localparam int K_GOOD    = 2;
  localparam int K_FERR    = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       RX;
  logic [7:0] data;
  logic       ready, frame_err, busy;

  uart_rx_core #(.CLK_HZ(1_600_000), .BAUD(10_000)) dut (
    .clk(clk), .reset(reset), .RX(RX),
    .data(data), .ready(ready), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  typedef struct { int t; int kind; logic [7:0] v; } ev_t;
  ev_t evq[$];
  ev_t ev;
  logic [7:0] m_data  = '0;
  logic       m_ready = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_busy  = 1'b0;
  logic       rdy_prev = 1'b0;
  int         rises = 0;
  int         falls = 0;
  int         rise_cyc = 0;

  // Model update and per-cycle comparison.
  always @(negedge clk) begin
    if (reset) begin
      evq.delete();
      m_data = '0; m_ready = 1'b0; m_ferr = 1'b0; m_busy = 1'b0;
    end else begin
      while (evq.size() != 0 && evq[0].t <= cyc) begin
        ev = evq.pop_front();
        case (ev.kind)
          K_BUSY: m_busy = ev.v[0];
          K_RDY0: m_ready = 1'b0;
          K_GOOD: begin m_data = ev.v; m_ready = 1'b1; m_ferr = 1'b0; m_busy = 1'b0; end
          default: m_ferr = 1'b1;
        endcase
      end
    end
    chk("cyc_data",      32'(data),      32'(m_data));
    chk("cyc_ready",     32'(ready),     32'(m_ready));
    chk("cyc_frame_err", 32'(frame_err), 32'(m_ferr));
    chk("cyc_busy",      32'(busy),      32'(m_busy));
    if (ready === 1'b1 && rdy_prev !== 1'b1) begin rises++; rise_cyc = cyc; end
    if (ready === 1'b0 && rdy_prev === 1'b1) falls++;
    rdy_prev = ready;
  end

  task automatic push(input int t, input int k, input logic [7:0] v);
    ev_t e;
    e.t = t; e.kind = k; e.v = v;
    evq.push_back(e);
  endtask

  task automatic frame_events(input int e0, input logic [7:0] b, input bit good);
    push(e0 + 2, K_BUSY, 8'd1);
    push(e0 + START_DEC, K_RDY0, 8'd0);
    if (good) push(e0 + LAT, K_GOOD, b);
    else      push(e0 + LAT, K_FERR, 8'd0);
  endtask

  // Called #1 after a rising edge; the level is seen by the next n rising edges.
  task automatic drive_bit(input logic v, input int n);
    RX = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int p, output int e0);
    e0 = cyc + 1;
    frame_events(e0, b, 1'b1);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(b[i], p);
    drive_bit(1'b1, p);
  endtask

  initial begin
    int e0, r0, base, fbase;
    logic [7:0] b55, b77;
    b55 = 8'h55;
    b77 = 8'h77;
    reset = 1'b1;
    RX = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_data",  32'(data),      32'h0);
    chk("rst_ready", 32'(ready),     32'h0);
    chk("rst_ferr",  32'(frame_err), 32'h0);
    chk("rst_busy",  32'(busy),      32'h0);
    reset = 1'b0;
    drive_bit(1'b1, 20);

    // Single byte, latency pinned from e0.
    send_byte(8'hA5, 160, e0);
    drive_bit(1'b1, 40);
    chk("a5_data",    32'(data),      32'hA5);
    chk("a5_ready",   32'(ready),     32'h1);
    chk("a5_ferr",    32'(frame_err), 32'h0);
    chk("a5_latency", rise_cyc - e0,  1542);
    chk("a5_rises",   rises,          1);

    // Back-to-back bytes with no idle gap.
    base = rises; fbase = falls;
    send_byte(8'h00, 160, e0);
    send_byte(8'hFF, 160, e0);
    send_byte(8'h3C, 160, e0);
    send_byte(8'h81, 160, e0);
    drive_bit(1'b1, 40);
    chk("b2b_rises", rises - base, 4);
    chk("b2b_falls", falls - fbase, 4);
    chk("b2b_data",  32'(data), 32'h81);

    // False start: 50-cycle low pulse.
    base = rises;
    e0 = cyc + 1;
    push(e0 + 2, K_BUSY, 8'd1);
    push(e0 + START_DEC, K_BUSY, 8'd0);
    drive_bit(1'b0, 50);
    drive_bit(1'b1, 40);
    chk("fs_busy_mid", 32'(busy), 32'h1);
    drive_bit(1'b1, 200);
    chk("fs_busy",  32'(busy), 32'h0);
    chk("fs_rises", rises - base, 0);
    chk("fs_data",  32'(data), 32'h81);

    // Framing error with the stop bit held low, then recovery.
    base = rises;
    e0 = cyc + 1;
    frame_events(e0, b55, 1'b0);
    drive_bit(1'b0, 160);
    for (int i = 0; i < 8; i++) drive_bit(b55[i], 160);
    drive_bit(1'b0, 400);
    r0 = cyc + 1;
    push(r0 + 2, K_BUSY, 8'd0);
    drive_bit(1'b1, 100);
    chk("fe_flag",  32'(frame_err), 32'h1);
    chk("fe_rises", rises - base, 0);
    chk("fe_data",  32'(data), 32'h81);
    chk("fe_ready", 32'(ready), 32'h0);
    chk("fe_busy",  32'(busy), 32'h0);
    send_byte(8'h12, 160, e0);
    drive_bit(1'b1, 40);
    chk("rec_data",  32'(data), 32'h12);
    chk("rec_ferr",  32'(frame_err), 32'h0);
    chk("rec_ready", 32'(ready), 32'h1);

    // Reset during data bit 4 of 0x77.
    base = rises;
    e0 = cyc + 1;
    frame_events(e0, b77, 1'b1);
    drive_bit(1'b0, 160);
    for (int i = 0; i < 4; i++) drive_bit(b77[i], 160);
    drive_bit(b77[4], 80);
    reset = 1'b1;
    RX = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mr_data",  32'(data),      32'h0);
    chk("mr_ready", 32'(ready),     32'h0);
    chk("mr_ferr",  32'(frame_err), 32'h0);
    chk("mr_busy",  32'(busy),      32'h0);
    reset = 1'b0;
    drive_bit(1'b1, 30);
    send_byte(8'h99, 160, e0);
    drive_bit(1'b1, 40);
    chk("mr99_data",  32'(data), 32'h99);
    chk("mr99_ready", 32'(ready), 32'h1);
    chk("mr99_rises", rises - base, 1);

    // Baud tolerance: +3% and -3% bit periods.
    base = rises;
    send_byte(8'hC3, 165, e0);
    drive_bit(1'b1, 100);
    chk("slow_data",  32'(data), 32'hC3);
    chk("slow_ferr",  32'(frame_err), 32'h0);
    chk("slow_rises", rises - base, 1);
    send_byte(8'hC3, 155, e0);
    drive_bit(1'b1, 100);
    chk("fast_data",  32'(data), 32'hC3);
    chk("fast_ferr",  32'(frame_err), 32'h0);
    chk("fast_rises", rises - base, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
